// File: rtl/mux32_2x1_sel_if.sv
// rtl/mux32_2x1_sel_if.sv - data/select bundle for the 2:1 word multiplexer
//
// Purpose : groups the data inputs, select, load enable and result of
//           mux32_2x1_sel so that instantiation sites connect a single bundle.
// Signals : I0, I1 (WIDTH) data inputs; S select; EN register load enable;
//           Y (WIDTH) selected word.
// Modports: master drives I0/I1/S/EN and observes Y; slave is the mux side.

interface mux32_2x1_sel_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             S;
    logic             EN;
    logic [WIDTH-1:0] Y;

    modport master (
        output I0,
        output I1,
        output S,
        output EN,
        input  Y
    );

    modport slave (
        input  I0,
        input  I1,
        input  S,
        input  EN,
        output Y
    );
endinterface

// File: rtl/mux32_2x1_sel.sv
// rtl/mux32_2x1_sel.sv - 32-bit 2:1 word multiplexer with optional output register
//
// Purpose : Y = S ? I1 : I0, built as WIDTH independent 1-bit mux slices that
//           share one select. Used for shifter direction select, shifter
//           zero-forcing and ALU operand/result steering.
// Ports   : CLK  rising-edge clock (registered build only)
//           RST  asynchronous active-high reset (registered build only)
//           bus  mux32_2x1_sel_if.slave: I0, I1, S, EN in; Y out
// Config  : MUX32_2X1_OUT_REG_EN defined   -> Y registered, loaded on CLK when
//                                             EN=1, cleared asynchronously by RST.
//           MUX32_2X1_OUT_REG_EN undefined -> purely combinational; CLK, RST
//                                             and EN are present but unused.

module mux32_2x1_sel #(
    parameter int WIDTH = 32
) (
    input  logic            CLK,
    input  logic            RST,
    mux32_2x1_sel_if.slave  bus
);

    logic [WIDTH-1:0] w_mux;

    // One slice per bit. The conditional operator is used rather than an
    // AND-OR form so that an unknown select still resolves bits where both
    // inputs agree, which matches the behaviour of a real mux cell.
    genvar g_bit;
    generate
        for (g_bit = 0; g_bit < WIDTH; g_bit++) begin : g_slice
            assign w_mux[g_bit] = bus.S ? bus.I1[g_bit] : bus.I0[g_bit];
        end
    endgenerate

`ifdef MUX32_2X1_OUT_REG_EN
    logic [WIDTH-1:0] r_y;

    // Reset is in the sensitivity list, so it clears Y immediately and wins
    // over a coincident clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_y <= '0;
        end else if (bus.EN) begin
            r_y <= w_mux;
        end
    end

    assign bus.Y = r_y;
`else
    // Clock, reset and enable are kept on the port list so that both builds
    // instantiate identically; they are deliberately left without a load here.
    logic w_unused_ctrl;
    assign w_unused_ctrl = CLK ^ RST ^ bus.EN;

    assign bus.Y = w_mux;
`endif

endmodule

// File: tb/tb_mux32_2x1_sel.sv
// tb/tb_mux32_2x1_sel.sv - scoreboard bench for mux32_2x1_sel (both builds)

module tb_mux32_2x1_sel;

    localparam int W = 32;
`ifdef MUX32_2X1_OUT_REG_EN
    localparam int LAT = 1;
    localparam bit REG = 1'b1;
`else
    localparam int LAT = 0;
    localparam bit REG = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mux32_2x1_sel_if #(.WIDTH(W)) bus ();

    mux32_2x1_sel #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] exp;
        int           due;
        string        name;
    } item_t;

    item_t        sb[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [W-1:0] model_y  = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops every expectation whose due cycle has arrived and compares
    // against Y half a cycle away from the active edge.
    always @(negedge CLK) begin : monitor
        item_t it;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            check(it.name, bus.Y, it.exp);
        end
    end

    // Reference: Y is the selected word; in the registered build it only
    // changes on an enabled edge, otherwise it tracks the inputs directly.
    task automatic apply(input logic [W-1:0] i0, input logic [W-1:0] i1,
                         input logic s, input logic en, input string name);
        logic [W-1:0] sel;
        @(posedge CLK);
        #1;
        bus.I0 = i0;
        bus.I1 = i1;
        bus.S  = s;
        bus.EN = en;
        sel = s ? i1 : i0;
        if (!REG || en) model_y = sel;
        sb.push_back('{model_y, cyc + LAT, name});
    endtask

    initial begin
        logic [W-1:0] one_hot;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           drained;

        bus.I0 = 32'hCAFE_F00D;
        bus.I1 = 32'h0123_4567;
        bus.S  = 1'b0;
        bus.EN = 1'b1;

        #12;
        check("reset_state", bus.Y, REG ? 32'h0 : 32'hCAFE_F00D);
        @(posedge CLK);
        #1 RST = 1'b0;

        apply(32'h0000_01E0, 32'h0000_0000, 1'b0, 1'b1, "t1_s0");
        apply(32'h0000_01E0, 32'h0000_0000, 1'b1, 1'b1, "t1_s1_zero_force");
        apply(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1, "t2_s0");
        apply(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1, "t2_s1");
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, "t3_ones_s0");
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, "t3_ones_s1");
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'bx, 1'b1, "t3_ones_sx");
        apply(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, "zeros");

        for (int k = 0; k < W; k++) begin
            one_hot = 32'h1 << k;
            apply(~one_hot, one_hot, 1'b1, 1'b1, "walk_s1");
            apply(~one_hot, one_hot, 1'b0, 1'b1, "walk_s0");
        end

        // Load then hold with EN low while the inputs keep moving.
        apply(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1, "hold_load");
        for (int k = 0; k < 3; k++) begin
            apply($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, "hold_en0");
        end

        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            b = (n % 10 == 0) ? a : $urandom;
            apply(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), "random");
        end

        // Mid-cycle reset pulse with no clock edge in between.
        apply(32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b1, "pre_reset_load");
        @(posedge CLK);
        @(negedge CLK);
        #1 RST = 1'b1;
        #1 check("reset_async", bus.Y, REG ? 32'h0 : 32'hDEAD_BEEF);
        #1 RST = 1'b0;
        if (REG) model_y = '0;
        #1 check("reset_release_hold", bus.Y, REG ? 32'h0 : 32'hDEAD_BEEF);
        apply(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1, "post_reset_load");

        drained = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK);
            if (sb.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        checks++;
        if (!drained) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
